temp_sched: RTL and testbench



---
 rtl/temp_sched.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_temp_sched.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_sched.sv
// ---------------------------------------------------------------------------
// temp_sched -- periodic measurement scheduler for a DS18B20 behind a
// single-op 1-Wire byte engine.
//
// Every PERIOD cycles in IDLE (or immediately on trig) it runs:
//   RESET, WRITE 0xCC (Skip ROM), WRITE 0x44 (Convert T),
//   wait CONV_WAIT cycles,
//   RESET, WRITE 0xCC, WRITE 0xBE (Read Scratchpad), READ LSB, READ MSB
// and publishes {MSB,LSB} on temp_data with a one-cycle temp_valid.
// A missing presence pulse or an op that exceeds TIMEOUT cycles aborts the
// sequence, raises dev_err and returns to IDLE; dev_err stays set until the
// next successful reading.
//
// Build option: define TEMP_CRC_EN to read the full 9-byte scratchpad and
// accept the reading only when the Dallas CRC-8 over bytes 0..7 matches
// byte 8. Without it only the two temperature bytes are read.
//
// Ports:
//   clk          system clock (50 MHz)
//   rst_n        asynchronous reset, active low
//   trig         one-cycle request for an immediate measurement (IDLE only)
//   ow_start     one-cycle op request to the engine
//   ow_op        0=RESET, 1=WRITE byte, 2=READ byte (valid with ow_start)
//   ow_wdata     byte to write (valid with ow_start)
//   ow_done      one-cycle op-complete pulse from the engine
//   ow_rdata     read byte (valid with ow_done on READ)
//   ow_presence  device answered (valid with ow_done on RESET)
//   temp_data    last good raw reading {MSB,LSB}
//   temp_valid   one-cycle pulse when temp_data updates
//   dev_err      sticky-until-success error flag
//   busy         high whenever the scheduler is not in IDLE
// ---------------------------------------------------------------------------
module temp_sched #(
  parameter logic [23:0] PERIOD    = 24'd10_000_000,
  parameter logic [25:0] CONV_WAIT = 26'd37_500_000,
  parameter logic [19:0] TIMEOUT   = 20'd500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trig,
  output logic        ow_start,
  output logic [1:0]  ow_op,
  output logic [7:0]  ow_wdata,
  input  logic        ow_done,
  input  logic [7:0]  ow_rdata,
  input  logic        ow_presence,
  output logic [15:0] temp_data,
  output logic        temp_valid,
  output logic        dev_err,
  output logic        busy
);

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

  localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
  localparam logic [7:0] CMD_CONVERT  = 8'h44;
  localparam logic [7:0] CMD_READ_SP  = 8'hBE;

  typedef enum logic [3:0] {
    IDLE,
    RST1,
    SKIP1,
    CONV,
    WAIT_CONV,
    RST2,
    SKIP2,
    RDCMD,
    RD_LSB,
    RD_MSB,
`ifdef TEMP_CRC_EN
    RD_REST,
`endif
    DONE
  } state_t;

  state_t      state;
  logic [23:0] period_cnt;
  logic [25:0] wait_cnt;
  logic [19:0] tmo_cnt;
  logic [7:0]  lsb_q;

  logic op_state;
  logic done_ok;
  logic tmo_hit;

`ifdef TEMP_CRC_EN
  logic [7:0] msb_q;
  logic [7:0] crc_q;
  logic [2:0] byte_cnt;

  // Dallas/Maxim CRC-8 (x^8+x^5+x^4+1), reflected, one byte LSB first.
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                           input logic [7:0] data);
    logic [7:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 8'h8C;
      else                c = c >> 1;
    end
    return c;
  endfunction
`endif

  // States that own an engine op and therefore run the timeout counter.
  assign op_state = (state != IDLE) && (state != WAIT_CONV) && (state != DONE);
  // A done in the same cycle as our own ow_start cannot belong to this op.
  assign done_ok  = ow_done && !ow_start;
  assign tmo_hit  = (tmo_cnt == TIMEOUT - 20'd1);

  // Sequencer: all control and published outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ow_start   <= 1'b0;
      ow_op      <= OP_RESET;
      ow_wdata   <= 8'h00;
      temp_data  <= 16'h0000;
      temp_valid <= 1'b0;
      dev_err    <= 1'b0;
      busy       <= 1'b0;
      period_cnt <= '0;
      wait_cnt   <= '0;
      tmo_cnt    <= '0;
`ifdef TEMP_CRC_EN
      byte_cnt   <= '0;
`endif
    end else begin
      ow_start   <= 1'b0;
      temp_valid <= 1'b0;

      if (op_state) begin
        if (done_ok || tmo_hit) tmo_cnt <= '0;
        else                    tmo_cnt <= tmo_cnt + 20'd1;
      end

      if (op_state && !done_ok && tmo_hit) begin
        // Engine never answered: abandon the sequence.
        dev_err <= 1'b1;
        busy    <= 1'b0;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (trig || (period_cnt == PERIOD - 24'd1)) begin
              period_cnt <= '0;
              busy       <= 1'b1;
              state      <= RST1;
              ow_start   <= 1'b1;
              ow_op      <= OP_RESET;
              ow_wdata   <= 8'h00;
            end else begin
              period_cnt <= period_cnt + 24'd1;
            end
          end

          RST1: begin
            if (done_ok) begin
              if (!ow_presence) begin
                dev_err <= 1'b1;
                busy    <= 1'b0;
                state   <= IDLE;
              end else begin
                state    <= SKIP1;
                ow_start <= 1'b1;
                ow_op    <= OP_WRITE;
                ow_wdata <= CMD_SKIP_ROM;
              end
            end
          end

          SKIP1: begin
            if (done_ok) begin
              state    <= CONV;
              ow_start <= 1'b1;
              ow_op    <= OP_WRITE;
              ow_wdata <= CMD_CONVERT;
            end
          end

          CONV: begin
            if (done_ok) begin
              wait_cnt <= '0;
              state    <= WAIT_CONV;
            end
          end

          WAIT_CONV: begin
            if (wait_cnt == CONV_WAIT - 26'd1) begin
              wait_cnt <= '0;
              state    <= RST2;
              ow_start <= 1'b1;
              ow_op    <= OP_RESET;
              ow_wdata <= 8'h00;
            end else begin
              wait_cnt <= wait_cnt + 26'd1;
            end
          end

          RST2: begin
            if (done_ok) begin
              if (!ow_presence) begin
                dev_err <= 1'b1;
                busy    <= 1'b0;
                state   <= IDLE;
              end else begin
                state    <= SKIP2;
                ow_start <= 1'b1;
                ow_op    <= OP_WRITE;
                ow_wdata <= CMD_SKIP_ROM;
              end
            end
          end

          SKIP2: begin
            if (done_ok) begin
              state    <= RDCMD;
              ow_start <= 1'b1;
              ow_op    <= OP_WRITE;
              ow_wdata <= CMD_READ_SP;
            end
          end

          RDCMD: begin
            if (done_ok) begin
              state    <= RD_LSB;
              ow_start <= 1'b1;
              ow_op    <= OP_READ;
              ow_wdata <= 8'h00;
            end
          end

          RD_LSB: begin
            if (done_ok) begin
              state    <= RD_MSB;
              ow_start <= 1'b1;
              ow_op    <= OP_READ;
              ow_wdata <= 8'h00;
            end
          end

          RD_MSB: begin
            if (done_ok) begin
`ifdef TEMP_CRC_EN
              byte_cnt <= '0;
              state    <= RD_REST;
              ow_start <= 1'b1;
              ow_op    <= OP_READ;
              ow_wdata <= 8'h00;
`else
              temp_data  <= {ow_rdata, lsb_q};
              temp_valid <= 1'b1;
              dev_err    <= 1'b0;
              state      <= DONE;
`endif
            end
          end

`ifdef TEMP_CRC_EN
          RD_REST: begin
            if (done_ok) begin
              // byte_cnt 0..5 are scratchpad bytes 2..7, 6 is the CRC byte.
              if (byte_cnt == 3'd6) begin
                if (ow_rdata == crc_q) begin
                  temp_data  <= {msb_q, lsb_q};
                  temp_valid <= 1'b1;
                  dev_err    <= 1'b0;
                  state      <= DONE;
                end else begin
                  dev_err <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
                end
              end else begin
                byte_cnt <= byte_cnt + 3'd1;
                ow_start <= 1'b1;
                ow_op    <= OP_READ;
                ow_wdata <= 8'h00;
              end
            end
          end
`endif

          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end

          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Scratchpad byte capture; these only feed temp_data after being written.
  always_ff @(posedge clk) begin
    if (done_ok && (state == RD_LSB)) lsb_q <= ow_rdata;
`ifdef TEMP_CRC_EN
    if (done_ok && (state == RD_MSB)) msb_q <= ow_rdata;
    if (done_ok) begin
      if (state == RD_LSB)
        crc_q <= crc8_byte(8'h00, ow_rdata);
      else if ((state == RD_MSB) || (state == RD_REST))
        crc_q <= crc8_byte(crc_q, ow_rdata);
    end
`endif
  end

endmodule

// File: tb/tb_temp_sched.sv
// ---------------------------------------------------------------------------
// tb_temp_sched -- self-checking bench for temp_sched.
// A behavioural 1-Wire engine answers each ow_start after a set or random
// number of cycles and supplies scratchpad bytes. Expected op order,
// readings and error behaviour come from the measurement procedure itself.
// ---------------------------------------------------------------------------
module tb_temp_sched;

  localparam int PER = 100;
  localparam int CW  = 50;
  localparam int TMO = 20;

  logic        clk;
  logic        rst_n;
  logic        trig;
  logic        ow_start;
  logic [1:0]  ow_op;
  logic [7:0]  ow_wdata;
  logic        ow_done     = 1'b0;
  logic [7:0]  ow_rdata    = 8'h00;
  logic        ow_presence = 1'b1;
  logic [15:0] temp_data;
  logic        temp_valid;
  logic        dev_err;
  logic        busy;

  temp_sched #(
    .PERIOD   (24'd100),
    .CONV_WAIT(26'd50),
    .TIMEOUT  (20'd20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trig       (trig),
    .ow_start   (ow_start),
    .ow_op      (ow_op),
    .ow_wdata   (ow_wdata),
    .ow_done    (ow_done),
    .ow_rdata   (ow_rdata),
    .ow_presence(ow_presence),
    .temp_data  (temp_data),
    .temp_valid (temp_valid),
    .dev_err    (dev_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef TEMP_CRC_EN
  localparam int NBYTES = 9;
`else
  localparam int NBYTES = 2;
`endif

  // ---------------- behavioural engine ----------------
  int         eng_delay    = 10;
  bit         eng_rand     = 1'b0;
  bit         eng_presence = 1'b1;
  logic [7:0] rd_bytes [0:8];
  int         rd_idx    = 0;
  int         remaining = 0;
  logic [1:0] pend_op   = 2'd0;
  int         proto_err = 0;
  logic [9:0] op_log [$];

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remaining = 0;
      ow_done   = 1'b0;
    end else begin
      ow_done     = 1'b0;
      ow_presence = eng_presence;
      if (remaining > 0) begin
        remaining = remaining - 1;
        if (remaining == 0) begin
          ow_done = 1'b1;
          if (pend_op == 2'd2) begin
            ow_rdata = (rd_idx < 9) ? rd_bytes[rd_idx] : 8'h00;
            rd_idx   = rd_idx + 1;
          end
        end
      end
      if (ow_start === 1'b1) begin
        if (remaining > 0) proto_err = proto_err + 1;
        op_log.push_back({ow_op, ow_wdata});
        pend_op = ow_op;
        if (ow_op == 2'd0) rd_idx = 0;
        remaining = eng_rand ? int'($urandom_range(15, 1)) : eng_delay;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [9:0]  exp_ops [$];
  logic [15:0] exp_temp;

  // Full measurement: two resets, two skip-ROMs, convert, read cmd, reads.
  task automatic make_exp_ops();
    exp_ops.delete();
    exp_ops.push_back({2'd0, 8'h00});
    exp_ops.push_back({2'd1, 8'hCC});
    exp_ops.push_back({2'd1, 8'h44});
    exp_ops.push_back({2'd0, 8'h00});
    exp_ops.push_back({2'd1, 8'hCC});
    exp_ops.push_back({2'd1, 8'hBE});
    for (int i = 0; i < NBYTES; i++) exp_ops.push_back({2'd2, 8'h00});
  endtask

  function automatic bit ops_match(input int base);
    if (op_log.size() - base != exp_ops.size()) return 1'b0;
    for (int i = 0; i < exp_ops.size(); i++)
      if (op_log[base + i] !== exp_ops[i]) return 1'b0;
    return 1'b1;
  endfunction

`ifdef TEMP_CRC_EN
  // Polynomial division of the bit stream (LSB of byte 0 first) by
  // x^8+x^5+x^4+1, expressed with the reflected constant.
  function automatic logic [7:0] model_crc();
    logic [7:0] r;
    logic       fb;
    r = 8'h00;
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < 8; k++) begin
        fb = r[0] ^ rd_bytes[b][k];
        r  = {1'b0, r[7:1]};
        if (fb) r = r ^ 8'h8C;
      end
    return r;
  endfunction
`endif

  // Loads the scratchpad the engine will return and yields the reading.
  task automatic load_bytes(input logic [7:0] lsb, input logic [7:0] msb,
                            output logic [15:0] reading);
    rd_bytes[0] = lsb;
    rd_bytes[1] = msb;
    for (int i = 2; i < 9; i++) rd_bytes[i] = 8'($urandom);
`ifdef TEMP_CRC_EN
    rd_bytes[8] = model_crc();
`endif
    reading = {msb, lsb};
  endtask

  // ---------------- sequencing helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic run_to_idle(input int max, output bit ok, output int vcount);
    int c;
    c = 0;
    ok = 1'b0;
    vcount = 0;
    while (c < max) begin
      if (temp_valid === 1'b1) vcount++;
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      tick();
      c++;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    trig  = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({ow_start, ow_op, ow_wdata, temp_data, temp_valid, dev_err, busy} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got start=%0b op=%0d wd=%02h td=%04h tv=%0b err=%0b busy=%0b want all 0",
               ow_start, ow_op, ow_wdata, temp_data, temp_valid, dev_err, busy);
    end
    exp_temp = 16'h0000;
    rst_n = 1'b1;
  endtask

  task automatic test_presence_fail();
    int base;
    bit ok;
    int vc;
    eng_presence = 1'b0;
    eng_rand     = 1'b0;
    eng_delay    = 10;
    base = op_log.size();
    pulse_trig();
    run_to_idle(200, ok, vc);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL presence_idle got busy=%0b want 0", busy); end
    n_checks++;
    if (dev_err !== 1'b1) begin n_fail++; $display("FAIL presence_err got %0b want 1", dev_err); end
    n_checks++;
    if ((op_log.size() - base != 1) || (op_log[base] !== {2'd0, 8'h00})) begin
      n_fail++;
      $display("FAIL presence_ops got %0d ops want 1 RESET", op_log.size() - base);
    end
    n_checks++;
    if (temp_data !== exp_temp || vc != 0) begin
      n_fail++;
      $display("FAIL presence_temp got %04h valid=%0d want %04h valid=0", temp_data, vc, exp_temp);
    end
    eng_presence = 1'b1;
  endtask

  task automatic test_random_cycles(input int n);
    int base;
    bit ok;
    int vc;
    logic [15:0] reading;
    eng_rand = 1'b1;
    make_exp_ops();
    for (int k = 0; k < n; k++) begin
      load_bytes(8'($urandom), 8'($urandom), reading);
      base = op_log.size();
      pulse_trig();
      run_to_idle(2000, ok, vc);
      exp_temp = reading;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rand_idle[%0d] got busy=%0b want 0", k, busy); end
      n_checks++;
      if (!ops_match(base)) begin
        n_fail++;
        $display("FAIL rand_ops[%0d] got %0d ops want %0d in order", k, op_log.size() - base, exp_ops.size());
      end
      n_checks++;
      if (temp_data !== exp_temp) begin
        n_fail++;
        $display("FAIL rand_temp[%0d] got %04h want %04h", k, temp_data, exp_temp);
      end
      n_checks++;
      if (vc != 1 || dev_err !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_valid[%0d] got pulses=%0d err=%0b want 1 and 0", k, vc, dev_err);
      end
    end
    eng_rand = 1'b0;
  endtask

  task automatic test_timeout();
    int base;
    int n;
    bit ok;
    int vc;
    logic [15:0] reading;
    eng_rand  = 1'b0;
    eng_delay = 30;
    base = op_log.size();
    pulse_trig();
    n = 0;
    while (dev_err !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != TMO) begin n_fail++; $display("FAIL timeout_cycles got %0d want %0d", n, TMO); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy got %0b want 0", busy); end
    // The late done lands in IDLE and must be ignored.
    repeat (15) tick();
    n_checks++;
    if (op_log.size() - base != 1 || busy !== 1'b0 || dev_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_late_done got ops=%0d busy=%0b err=%0b want 1 0 1",
               op_log.size() - base, busy, dev_err);
    end
    eng_delay = 10;
    make_exp_ops();
    load_bytes(8'h91, 8'h01, reading);
    base = op_log.size();
    pulse_trig();
    run_to_idle(2000, ok, vc);
    exp_temp = reading;
    n_checks++;
    if (!ok || dev_err !== 1'b0 || temp_data !== exp_temp || vc != 1) begin
      n_fail++;
      $display("FAIL timeout_recover got err=%0b td=%04h pulses=%0d want 0 %04h 1",
               dev_err, temp_data, vc, exp_temp);
    end
  endtask

  task automatic test_trig_and_period();
    int base;
    int c;
    int vc;
    int n;
    bit ok;
    logic [15:0] reading;
    eng_delay = 10;
    make_exp_ops();
    load_bytes(8'h91, 8'h01, reading);
    repeat (5) tick();
    base = op_log.size();
    pulse_trig();
    n_checks++;
    if (ow_start !== 1'b1 || ow_op !== 2'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL trig_start got start=%0b op=%0d busy=%0b want 1 0 1", ow_start, ow_op, busy);
    end
    // Extra trig pulses while busy must not start anything.
    c = 0; vc = 0; ok = 1'b0;
    while (c < 2000) begin
      if (temp_valid === 1'b1) vc++;
      if (busy === 1'b0) begin ok = 1'b1; break; end
      trig = (c % 13 == 7);
      tick();
      c++;
    end
    trig = 1'b0;
    exp_temp = reading;
    n_checks++;
    if (!ok || !ops_match(base)) begin
      n_fail++;
      $display("FAIL trig_busy_ops got %0d ops want %0d", op_log.size() - base, exp_ops.size());
    end
    n_checks++;
    if (temp_data !== 16'h0191 || vc != 1 || dev_err !== 1'b0) begin
      n_fail++;
      $display("FAIL trig_temp got %04h pulses=%0d err=%0b want 0191 1 0", temp_data, vc, dev_err);
    end
    // Auto-start PERIOD cycles after entering IDLE.
    load_bytes(8'($urandom), 8'($urandom), reading);
    n = 0;
    while (ow_start !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    n_checks++;
    if (n != PER || op_log.size() - base != exp_ops.size() + 1) begin
      n_fail++;
      $display("FAIL period_start got %0d cycles ops=%0d want %0d and %0d",
               n, op_log.size() - base, PER, exp_ops.size() + 1);
    end
    run_to_idle(2000, ok, vc);
    exp_temp = reading;
    n_checks++;
    if (!ok || temp_data !== exp_temp || vc != 1) begin
      n_fail++;
      $display("FAIL period_temp got %04h pulses=%0d want %04h 1", temp_data, vc, exp_temp);
    end
  endtask

  task automatic test_reset_midseq();
    int base;
    int n;
    bit glitch;
    bit ok;
    int vc;
    logic [15:0] reading;
    eng_delay = 10;
    base = op_log.size();
    pulse_trig();
    repeat (45) tick();
    n_checks++;
    if (busy !== 1'b1 || op_log.size() - base != 3) begin
      n_fail++;
      $display("FAIL midseq_wait got busy=%0b ops=%0d want 1 3", busy, op_log.size() - base);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_temp = 16'h0000;
    n_checks++;
    if ({ow_start, ow_op, ow_wdata, temp_data, temp_valid, dev_err, busy} !== 30'd0) begin
      n_fail++;
      $display("FAIL midseq_reset got start=%0b op=%0d wd=%02h td=%04h tv=%0b err=%0b busy=%0b want all 0",
               ow_start, ow_op, ow_wdata, temp_data, temp_valid, dev_err, busy);
    end
    glitch = 1'b0;
    repeat (3) begin
      tick();
      if (ow_start !== 1'b0) glitch = 1'b1;
    end
    load_bytes(8'($urandom), 8'($urandom), reading);
    rst_n = 1'b1;
    n = 0;
    while (ow_start !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    n_checks++;
    if (glitch || n != PER) begin
      n_fail++;
      $display("FAIL midseq_restart got glitch=%0b first_start=%0d want 0 %0d", glitch, n, PER);
    end
    run_to_idle(2000, ok, vc);
    exp_temp = reading;
    n_checks++;
    if (!ok || temp_data !== exp_temp || vc != 1) begin
      n_fail++;
      $display("FAIL midseq_temp got %04h pulses=%0d want %04h 1", temp_data, vc, exp_temp);
    end
  endtask

`ifdef TEMP_CRC_EN
  task automatic test_crc_mismatch();
    bit ok;
    int vc;
    logic [15:0] reading;
    load_bytes(8'h91, 8'h01, reading);
    rd_bytes[8] = rd_bytes[8] ^ 8'h5A;
    pulse_trig();
    run_to_idle(2000, ok, vc);
    n_checks++;
    if (!ok || dev_err !== 1'b1 || vc != 0 || temp_data !== exp_temp) begin
      n_fail++;
      $display("FAIL crc_bad got err=%0b pulses=%0d td=%04h want 1 0 %04h",
               dev_err, vc, temp_data, exp_temp);
    end
  endtask
`endif

  task automatic test_protocol();
    n_checks++;
    if (proto_err != 0) begin
      n_fail++;
      $display("FAIL ow_start_overlap got %0d want 0", proto_err);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    trig  = 1'b0;
    test_reset();
    test_presence_fail();
    test_random_cycles(6);
    test_timeout();
    test_trig_and_period();
    test_reset_midseq();
`ifdef TEMP_CRC_EN
    test_crc_mismatch();
`endif
    test_protocol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
